// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the ALU arbiter slice.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational N-bit ALU: add/sub/or/xor with carry (borrow on sub) and zero.
module alu_core
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  output logic [N-1:0] y,
  output logic         carry,
  output logic         zero
);

  logic [N:0] sum;
  logic [N:0] diff;

  // Bit N of the widened difference is the unsigned borrow (a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      ALU_ADD: {carry, y} = sum;
      ALU_SUB: {carry, y} = diff;
      ALU_OR:  y = a | b;
      default: y = a ^ b;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter/sequencer for one shared ALU.
// Define ALU_ARB_FLAGS_EN to add registered resp_carry/resp_zero outputs.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [N-1:0]       a0,
  input  logic [N-1:0]       b0,
  input  logic [1:0]         op0,
  input  logic [N-1:0]       a1,
  input  logic [N-1:0]       b1,
  input  logic [1:0]         op1,
  output logic [NUM_REQ-1:0] resp_valid,
  input  logic [NUM_REQ-1:0] resp_ready,
  output logic [N-1:0]       resp_result,
`ifdef ALU_ARB_FLAGS_EN
  output logic               resp_carry,
  output logic               resp_zero,
`endif
  output logic               grant_id,
  output logic               busy
);

  arb_state_t state, state_nxt;

  logic                      last_ptr;
  logic                      win;
  logic                      accept;
  logic [NUM_REQ-1:0][N-1:0] a_vec, b_vec;
  logic [NUM_REQ-1:0][1:0]   op_vec;
  logic [N-1:0]              a_q, b_q;
  logic [1:0]                op_q;
  logic [N-1:0]              alu_y;
  logic                      alu_c, alu_z;

  assign a_vec  = {a1, a0};
  assign b_vec  = {b1, b0};
  assign op_vec = {op1, op0};

  // A lone requester always wins; on contention the one not last served wins.
  always_comb begin
    win = 1'b1;
    if (req_valid[0]) win = req_valid[1] ? ~last_ptr : 1'b0;
  end

  assign accept     = (state == IDLE) && (|req_valid);
  assign req_ready  = accept ? (win ? 2'b10 : 2'b01) : 2'b00;
  assign resp_valid = (state == RESP) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready[grant_id]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ptr <= 1'b1;
      grant_id <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
    end else if (accept) begin
      last_ptr <= win;
      grant_id <= win;
      a_q      <= a_vec[win];
      b_q      <= b_vec[win];
      op_q     <= op_vec[win];
    end
  end

  alu_core #(.N(N)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .y     (alu_y),
    .carry (alu_c),
    .zero  (alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              resp_result <= '0;
    else if (state == EXEC)  resp_result <= alu_y;
  end

`ifdef ALU_ARB_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_carry <= 1'b0;
      resp_zero  <= 1'b0;
    end else if (state == EXEC) begin
      resp_carry <= alu_c;
      resp_zero  <= alu_z;
    end
  end
`else
  logic unused_flags;
  assign unused_flags = alu_c ^ alu_z;
`endif

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared N-bit ALU (opcodes: add, sub, or, xor). Each requester submits one operation with a valid/ready handshake. The block grants the ALU to one requester at a time, registers operands and result, and returns the result over a per-requester response handshake. It sits between the two operand sources of the datapath and the single ALU instance, so the ALU is never driven by more than one source.

## Interface
- N, default 8: operand and result width, N ≥ 1.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: operation from requester i is accepted this cycle
- a0, b0  in  N each  requester 0 operands
- op0  in  2  requester 0 opcode
- a1, b1  in  N each  requester 1 operands
- op1  in  2  requester 1 opcode
- resp_valid  out  2  bit i: result for requester i is available
- resp_ready  in  2  bit i: requester i takes the result
- resp_result  out  N  result, shared by both requesters and qualified by resp_valid
- grant_id  out  1  requester currently owning the ALU
- busy  out  1  high in EXEC or RESP

## Operation
- Opcodes: 2'b00 a+b, 2'b10 a−b, 2'b01 a|b, 2'b11 a^b.
- All arithmetic is modulo 2^N. Sub wraps, for example 0x05−0x07 = 0xFE at N=8.
- FSM states:
  - IDLE: arbitrate. If any req_valid is high, assert req_ready for exactly the winner.
  - EXEC: the ALU evaluates the latched operands.
  - RESP: resp_valid[grant_id] is held high until resp_ready[grant_id].
- Transitions:
  - IDLE→EXEC on req_valid[i] & req_ready[i]. On that edge, latch a, b, op and set grant_id=i.
  - EXEC→RESP unconditionally. On that edge, latch the ALU output into resp_result.
  - RESP→IDLE on resp_valid & resp_ready of the granted requester.
- Arbitration:
  - A last-served pointer records the previous winner and resets to 1, so requester 0 wins first.
  - When both requesters are valid, the one not last served wins.
  - When only one is valid, it wins regardless of the pointer.
  - The pointer updates on each accept.
- req_ready is combinational from state and req_valid. It is 2'b00 outside IDLE and never 2'b11.
- resp_ready for the non-granted requester is ignored. resp_ready in states other than RESP is ignored.
- Requester operands may change freely while that requester is not being accepted.

## Timing
- Reset values:
  - req_ready=0, resp_valid=0, resp_result=0, grant_id=0, busy=0.
  - State IDLE, pointer=1.
- Latency: an accept at edge k gives EXEC in cycle k+1 and resp_valid high from cycle k+2.
- Minimum occupancy is 3 cycles per operation. A new accept can happen in the cycle after the RESP handshake edge.
- resp_result and resp_valid stay stable throughout RESP until the handshake.
- Simultaneous resp handshake and a new req_valid: the request waits for IDLE (next cycle). There is no bypass.
- Reset asserted in any state clears all outputs immediately, abandons the in-flight operation (no response) and returns the pointer to 1.

## Configuration
- ALU_ARB_FLAGS_EN defined:
  - Adds outputs resp_carry (1 bit) and resp_zero (1 bit), registered together with resp_result. Both reset to 0.
  - resp_carry is the carry-out for add and the borrow (a<b unsigned) for sub. It is 0 for or/xor.
  - resp_zero is high when the result is 0.
- ALU_ARB_FLAGS_EN undefined: the flag ports and their logic are absent. All other behaviour is identical.

## Structure
- Shared package/header alu_pkg:
  - Opcode constants ALU_ADD, ALU_SUB, ALU_OR, ALU_XOR.
  - FSM state encodings IDLE, EXEC, RESP.
- One sub-module, alu_core:
  - Purely combinational N-bit ALU on the latched operands.
  - Also produces carry and zero, used only when ALU_ARB_FLAGS_EN is defined.
- The arbiter, FSM and registers live in the top module.

## Test plan
All cases use N=8.
- Single add: requester 0 sends a=0xF0, b=0x20, op=00, resp_ready=1. Response: resp_valid[0] two cycles after accept, resp_result=0x10; with flags, carry=1 and zero=0.
- Contention right after reset:
  - Both requesters valid. Requester 0 sends 0x05−0x07; requester 1 sends 0xAA^0x0F.
  - Requester 0 is served first with 0xFE.
  - Requester 1 is accepted the cycle after that handshake, with result 0xA5.
- Fairness: both requesters continuously valid for 4 operations → grant order 0,1,0,1, and req_ready is never 2'b11.
- Backpressure: OR 0x0C|0x30 with resp_ready=0 for 5 cycles → resp_valid stays high, resp_result stays 0x3C, req_ready stays 0, busy stays 1. The handshake is released on the 6th cycle.
- Reset during EXEC: rst_n pulses low → all outputs are 0 immediately and no response appears. The next request from requester 1 alone is accepted normally.
- Zero result: 0x5A^0x5A → resp_result=0x00; with flags, zero=1.
